// File: rtl/arm_alu_seq_if.sv
// Handshake, operand/result and flag-register bus between the control unit and arm_alu_seq.
interface arm_alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flags_wr;
  logic [3:0]       flags_in;
  logic [3:0]       flags_out;

  modport master (
    output in_valid, op, a, b, s_en, out_ready, flags_wr, flags_in,
    input  in_ready, out_valid, result, flags_out
  );

  modport slave (
    input  in_valid, op, a, b, s_en, out_ready, flags_wr, flags_in,
    output in_ready, out_valid, result, flags_out
  );
endinterface

// File: rtl/arm_alu_seq.sv
// Registered ARM ALU with NZCV flag register, valid/ready handshake and an
// iterative shift-add multiplier (one partial product per cycle).
module arm_alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          reset_n,
  arm_alu_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  localparam logic [4:0] OpMul = 5'b10010;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_s_q;

  logic             accept;
  logic [3:0]       flags_base;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic             alu_arith;
  logic             alu_logic;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       mul_flags;

  assign bus.in_ready  = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.flags_out = flags_q;

  // Flag value before any completion update: an MSR write lands here, completion overrides it.
  assign flags_base = bus.flags_wr ? bus.flags_in : flags_q;

  // Single-cycle datapath. Subtraction is x + ~y + cin so sum[WIDTH] is ARM's NOT-borrow.
  // Carry-in for ADC/SBC/RSC comes from flags_q, i.e. before any concurrent MSR write.
  always_comb begin
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    alu_arith = 1'b0;
    alu_logic = 1'b0;
    alu_res   = '0;
    unique case (bus.op)
      5'b00000, 5'b01000: begin alu_res = bus.a & bus.b;  alu_logic = 1'b1; end
      5'b00001, 5'b01001: begin alu_res = bus.a ^ bus.b;  alu_logic = 1'b1; end
      5'b01100:           begin alu_res = bus.a | bus.b;  alu_logic = 1'b1; end
      5'b01110:           begin alu_res = bus.a & ~bus.b; alu_logic = 1'b1; end
      5'b01111:           begin alu_res = ~bus.b;         alu_logic = 1'b1; end
      5'b10000:           begin alu_res = bus.b;          alu_logic = 1'b1; end
      5'b00010, 5'b01010: begin
        add_x = bus.a; add_y = ~bus.b; add_cin = 1'b1;       alu_arith = 1'b1;
      end
      5'b00011: begin add_x = bus.b; add_y = ~bus.a; add_cin = 1'b1;       alu_arith = 1'b1; end
      5'b00100, 5'b01011: begin
        add_x = bus.a; add_y = bus.b;  add_cin = 1'b0;       alu_arith = 1'b1;
      end
      5'b00101: begin add_x = bus.a; add_y = bus.b;  add_cin = flags_q[1]; alu_arith = 1'b1; end
      5'b00110: begin add_x = bus.a; add_y = ~bus.b; add_cin = flags_q[1]; alu_arith = 1'b1; end
      5'b00111: begin add_x = bus.b; add_y = ~bus.a; add_cin = flags_q[1]; alu_arith = 1'b1; end
      5'b10001: begin add_x = bus.a; add_y = '0;     add_cin = 1'b1;       alu_arith = 1'b1; end
      default: ;
    endcase
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
    if (alu_arith) alu_res = sum[WIDTH-1:0];
    alu_flags = flags_base;
    if (alu_arith) begin
      alu_flags = {alu_res[WIDTH-1], alu_res == '0, sum[WIDTH], add_v};
    end else if (alu_logic) begin
      alu_flags = {alu_res[WIDTH-1], alu_res == '0, flags_base[1:0]};
    end
  end

  // One shift-add step of the multiplier and the N/Z update it produces on completion.
  always_comb begin
    acc_next  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mul_flags = {acc_next[WIDTH-1], acc_next == '0, flags_base[1:0]};
  end

  // Control FSM with registered result, out_valid and flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      mul_s_q     <= 1'b0;
    end else begin
      flags_q <= flags_base;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (bus.op == OpMul) begin
              acc_q       <= '0;
              mcand_q     <= bus.a;
              mplier_q    <= bus.b;
              cnt_q       <= '0;
              mul_s_q     <= bus.s_en;
              out_valid_q <= 1'b0;
              state_q     <= StMul;
            end else begin
              result_q    <= alu_res;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
              if (bus.s_en) flags_q <= alu_flags;
            end
          end else if (bus.in_ready) begin
            // Idle, or DONE being drained with no follow-on op.
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StMul: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q    <= acc_next;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
            if (mul_s_q) flags_q <= mul_flags;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_alu_seq.sv
// Directed bench for arm_alu_seq: vector table for single-cycle ops plus MUL/handshake/reset
// sequences.
module tb_arm_alu_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  arm_alu_seq_if #(.WIDTH(W)) bus ();

  arm_alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  pre;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] v);
    bus.flags_wr = 1'b1;
    bus.flags_in = v;
    @(posedge clk); #1;
    bus.flags_wr = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.s_en     = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int busy;
    int seen;
    vecs[0]  = '{5'b00100, 32'h7FFFFFFF, 32'h00000001, 1'b1, 4'b0000, 32'h80000000, 4'b1001};
    vecs[1]  = '{5'b00010, 32'h00000005, 32'h00000005, 1'b1, 4'b0000, 32'h00000000, 4'b0110};
    vecs[2]  = '{5'b00010, 32'h00000003, 32'h00000005, 1'b1, 4'b0000, 32'hFFFFFFFE, 4'b1000};
    vecs[3]  = '{5'b00101, 32'h00000001, 32'h00000001, 1'b0, 4'b0010, 32'h00000003, 4'b0010};
    vecs[4]  = '{5'b00000, 32'hF0F00000, 32'hFF000000, 1'b1, 4'b0011, 32'hF0000000, 4'b1011};
    vecs[5]  = '{5'b00001, 32'h00001234, 32'h00001234, 1'b1, 4'b0000, 32'h00000000, 4'b0100};
    vecs[6]  = '{5'b00011, 32'h00000001, 32'h00000000, 1'b1, 4'b0000, 32'hFFFFFFFF, 4'b1000};
    vecs[7]  = '{5'b00110, 32'h00000005, 32'h00000003, 1'b1, 4'b0000, 32'h00000001, 4'b0010};
    vecs[8]  = '{5'b00111, 32'h00000003, 32'h00000005, 1'b1, 4'b0010, 32'h00000002, 4'b0010};
    vecs[9]  = '{5'b01100, 32'h00000000, 32'h00000000, 1'b1, 4'b1111, 32'h00000000, 4'b0111};
    vecs[10] = '{5'b01110, 32'hFFFFFFFF, 32'h0000FFFF, 1'b1, 4'b0000, 32'hFFFF0000, 4'b1000};
    vecs[11] = '{5'b01111, 32'h00000000, 32'hFFFFFFFF, 1'b1, 4'b0010, 32'h00000000, 4'b0110};
    vecs[12] = '{5'b10000, 32'h00000000, 32'h80000000, 1'b1, 4'b0001, 32'h80000000, 4'b1001};
    vecs[13] = '{5'b10001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4'b0000, 32'h00000000, 4'b0110};
    vecs[14] = '{5'b10001, 32'h7FFFFFFF, 32'h00000000, 1'b1, 4'b0000, 32'h80000000, 4'b1001};
    vecs[15] = '{5'b01010, 32'h80000000, 32'h00000001, 1'b1, 4'b0000, 32'h7FFFFFFF, 4'b0011};
    vecs[16] = '{5'b01011, 32'hFFFFFFFF, 32'h00000001, 1'b1, 4'b0000, 32'h00000000, 4'b0110};
    vecs[17] = '{5'b01000, 32'h00000001, 32'h00000002, 1'b1, 4'b0000, 32'h00000000, 4'b0100};
    vecs[18] = '{5'b01001, 32'h80000000, 32'h00000000, 1'b1, 4'b0000, 32'h80000000, 4'b1000};
    vecs[19] = '{5'b01101, 32'h00000005, 32'h00000006, 1'b1, 4'b1010, 32'h00000000, 4'b1010};
    vecs[20] = '{5'b00100, 32'h00000001, 32'h00000002, 1'b0, 4'b0101, 32'h00000003, 4'b0101};

    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.s_en      = 1'b0;
    bus.out_ready = 1'b1;
    bus.flags_wr  = 1'b0;
    bus.flags_in  = '0;

    // Reset state.
    #12;
    chk("rst_result", bus.result, 32'h0);
    chk("rst_flags", bus.flags_out, 4'h0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops: result and flags one cycle after accept.
    for (int i = 0; i < 21; i++) begin
      set_flags(vecs[i].pre);
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, 1'b1);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), bus.flags_out, vecs[i].fl);
    end

    // MUL latency, then held result under back-pressure.
    set_flags(4'b0100);
    bus.out_ready = 1'b0;
    issue(5'b10010, 32'h00010003, 32'h00010000, 1'b1);
    busy = 0;
    while (!bus.out_valid && busy < 40) begin
      if (bus.in_ready) begin
        errors++;
        $display("FAIL mul_busy_in_ready: got 1 expected 0 at busy cycle %0d", busy);
      end
      busy++;
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", busy, 32);
    chk("mul_out_valid", bus.out_valid, 1'b1);
    chk("mul_result", bus.result, 32'h00030000);
    chk("mul_flags", bus.flags_out, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_out_valid", k), bus.out_valid, 1'b1);
      chk($sformatf("hold%0d_result", k), bus.result, 32'h00030000);
      chk($sformatf("hold%0d_in_ready", k), bus.in_ready, 1'b0);
    end
    // Drain and accept the next op in the same cycle.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 5'b00100;
    bus.a         = 32'h2;
    bus.b         = 32'h3;
    bus.s_en      = 1'b1;
    #1;
    chk("b2b_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_out_valid", bus.out_valid, 1'b1);
    chk("b2b_result", bus.result, 32'h5);
    chk("b2b_flags", bus.flags_out, 4'b0000);

    // MSR write while DONE is stalled.
    bus.out_ready = 1'b0;
    set_flags(4'b1010);
    chk("msr_done_flags", bus.flags_out, 4'b1010);
    chk("msr_done_result", bus.result, 32'h5);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_out_valid", bus.out_valid, 1'b0);

    // ADC carry comes from the flag register at accept, not the concurrent MSR write.
    set_flags(4'b0000);
    bus.flags_wr = 1'b1;
    bus.flags_in = 4'b0010;
    issue(5'b00101, 32'h1, 32'h1, 1'b0);
    bus.flags_wr = 1'b0;
    chk("adc_msr_result", bus.result, 32'h2);
    chk("adc_msr_flags", bus.flags_out, 4'b0010);

    // Reset during MUL cycle 10 aborts it.
    issue(5'b10010, 32'h3, 32'h5, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("abort_result", bus.result, 32'h0);
    chk("abort_flags", bus.flags_out, 4'h0);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    // Completion flag update beats a coincident MSR write.
    bus.flags_wr = 1'b1;
    bus.flags_in = 4'b1111;
    issue(5'b00010, 32'h5, 32'h5, 1'b1);
    bus.flags_wr = 1'b0;
    chk("sub_msr_result", bus.result, 32'h0);
    chk("sub_msr_flags", bus.flags_out, 4'b0110);
    @(posedge clk); #1;
    chk("sub_msr_flags_after", bus.flags_out, 4'b0110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
